// File: rtl/lock_pkg.sv
// Shared state type, default sizing constants and a small helper for the
// combination-lock controller.
package lock_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        CHECK,
        UNLOCKED,
        ERROR,
        LOCKOUT
    } lock_state_t;

    localparam int unsigned DEF_NUM_BTN = 4;
    localparam int unsigned DEF_DIGIT_W = $clog2(DEF_NUM_BTN);

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for debounced button levels. The history register
// resets to all ones so a button already held at reset release is not a press.
module rise_detect #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] in_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q <= '1;
        end else begin
            in_q <= in;
        end
    end

    assign rise = in & ~in_q;

endmodule

// File: rtl/lock_fsm.sv
// Combination-lock controller: collects CODE_LEN digit presses, checks them
// against CODE, drives unlock/error/lockout. Optional: LOCK_ENTRY_TIMEOUT_EN.
module lock_fsm
    import lock_pkg::*;
#(
    parameter  int unsigned NUM_BTN        = DEF_NUM_BTN,
    localparam int unsigned DIGIT_W        = $clog2(NUM_BTN),
    parameter  int unsigned CODE_LEN       = 4,
    parameter  logic [DIGIT_W*CODE_LEN-1:0] CODE = 8'b11_10_01_00,
    parameter  int unsigned MAX_FAILS      = 3,
    parameter  int unsigned UNLOCK_CYCLES  = 500_000_000,
    parameter  int unsigned LOCKOUT_CYCLES = 1_000_000_000,
    parameter  int unsigned ENTRY_TIMEOUT  = 300_000_000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_BTN-1:0]              btn,
    output logic                            unlocked,
    output logic                            error,
    output logic                            locked_out,
    output logic [$clog2(CODE_LEN+1)-1:0]   digit_cnt,
    output logic [$clog2(MAX_FAILS+1)-1:0]  fail_cnt
);

    localparam int unsigned CNT_W   = $clog2(CODE_LEN + 1);
    localparam int unsigned FAIL_W  = $clog2(MAX_FAILS + 1);
    localparam int unsigned TMR_MAX = max_u(max_u(UNLOCK_CYCLES, LOCKOUT_CYCLES), ENTRY_TIMEOUT);
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [CNT_W-1:0]  LAST_IDX    = CNT_W'(CODE_LEN - 1);
    localparam logic [FAIL_W-1:0] FAIL_LIMIT  = FAIL_W'(MAX_FAILS);
    localparam logic [TMR_W-1:0]  UNLOCK_LOAD = TMR_W'(UNLOCK_CYCLES - 1);
    localparam logic [TMR_W-1:0]  LOCK_LOAD   = TMR_W'(LOCKOUT_CYCLES - 1);
`ifdef LOCK_ENTRY_TIMEOUT_EN
    localparam logic [TMR_W-1:0]  ENTRY_LOAD  = TMR_W'(ENTRY_TIMEOUT - 1);
`endif

    lock_state_t        state_q, state_d;
    logic [CNT_W-1:0]   cnt_d;
    logic [FAIL_W-1:0]  fail_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               mis_q, mis_d;

    logic [NUM_BTN-1:0] rise;
    logic [DIGIT_W-1:0] digit;
    logic [DIGIT_W-1:0] code_digit;
    logic               press;
    logic               bad_digit;

    rise_detect #(
        .WIDTH (NUM_BTN)
    ) u_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (btn),
        .rise  (rise)
    );

    always_comb begin
        digit = '0;
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            if (rise[i]) begin
                digit = DIGIT_W'(i);
            end
        end
    end

    assign press      = (rise != '0);
    assign code_digit = CODE[DIGIT_W*digit_cnt +: DIGIT_W];
    // A multi-button press still consumes a digit slot but can never match.
    assign bad_digit  = ($countones(rise) > 1) || (digit != code_digit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            digit_cnt <= '0;
            fail_cnt  <= '0;
            mis_q     <= 1'b0;
            tmr_q     <= '0;
        end else begin
            state_q   <= state_d;
            digit_cnt <= cnt_d;
            fail_cnt  <= fail_d;
            mis_q     <= mis_d;
            tmr_q     <= tmr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = digit_cnt;
        fail_d  = fail_cnt;
        mis_d   = mis_q;
        tmr_d   = (tmr_q != '0) ? tmr_q - 1'b1 : '0;

        case (state_q)
            IDLE: begin
                if (press) begin
                    state_d = ENTRY;
                    cnt_d   = CNT_W'(1);
                    mis_d   = bad_digit;
`ifdef LOCK_ENTRY_TIMEOUT_EN
                    tmr_d   = ENTRY_LOAD;
`endif
                end
            end
            ENTRY: begin
                if (press) begin
                    cnt_d = digit_cnt + 1'b1;
                    mis_d = mis_q | bad_digit;
                    if (digit_cnt == LAST_IDX) begin
                        state_d = CHECK;
                    end
`ifdef LOCK_ENTRY_TIMEOUT_EN
                    tmr_d = ENTRY_LOAD;
                end else if (tmr_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    mis_d   = 1'b0;
`endif
                end
            end
            CHECK: begin
                cnt_d = '0;
                mis_d = 1'b0;
                if (!mis_q) begin
                    state_d = UNLOCKED;
                    fail_d  = '0;
                    tmr_d   = UNLOCK_LOAD;
                end else begin
                    state_d = ERROR;
                    fail_d  = (fail_cnt == FAIL_LIMIT) ? fail_cnt : fail_cnt + 1'b1;
                end
            end
            UNLOCKED: begin
                if (press || tmr_q == '0) begin
                    state_d = IDLE;
                end
            end
            ERROR: begin
                if (fail_cnt == FAIL_LIMIT) begin
                    state_d = LOCKOUT;
                    tmr_d   = LOCK_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOCKOUT: begin
                if (tmr_q == '0) begin
                    state_d = IDLE;
                    fail_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign unlocked   = (state_q == UNLOCKED);
    assign error      = (state_q == ERROR);
    assign locked_out = (state_q == LOCKOUT);

endmodule

// File: tb/tb_lock_fsm.sv
// Randomized scoreboard bench for lock_fsm with a timeline-level reference model.
module tb_lock_fsm;
    import lock_pkg::*;

    localparam int UNL  = 20;
    localparam int LCK  = 50;
    localparam int TOUT = 30;
    localparam int NDIG = 4;
    localparam int MAXF = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn;
    logic       unlocked, error, locked_out;
    logic [2:0] digit_cnt;
    logic [1:0] fail_cnt;

    lock_fsm #(
        .NUM_BTN        (4),
        .CODE_LEN       (NDIG),
        .CODE           (8'b11_10_01_00),
        .MAX_FAILS      (MAXF),
        .UNLOCK_CYCLES  (UNL),
        .LOCKOUT_CYCLES (LCK),
        .ENTRY_TIMEOUT  (TOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn        (btn),
        .unlocked   (unlocked),
        .error      (error),
        .locked_out (locked_out),
        .digit_cnt  (digit_cnt),
        .fail_cnt   (fail_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef enum int {EV_UON, EV_UOFF, EV_ERR, EV_EOFF, EV_LON, EV_LOFF} ev_t;
    typedef struct {
        ev_t kind;
        int  at;
        int  fc;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: entered digits, consecutive failures, and the edges
    // from which presses are accepted again.
    int         digits[$];
    int         fails       = 0;
    int         accept_from = 0;
    bit         unl_active  = 0;
    int         unl_end     = 0;
    int         full_at     = -1;
    int         last_press  = 0;
    logic [3:0] prev_btn    = '1;
    logic [7:0] code_v      = 8'b11_10_01_00;

    function automatic void chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic void push(ev_t k, int at, int fc);
        exp_t x;
        x.kind = k; x.at = at; x.fc = fc;
        exp_q.push_back(x);
    endfunction

    function automatic int code_digit(int i);
        logic [DEF_DIGIT_W-1:0] d;
        d = code_v[DEF_DIGIT_W*i +: DEF_DIGIT_W];
        return int'(d);
    endfunction

    function automatic void finish_attempt(int p);
        bit match = 1;
        for (int i = 0; i < NDIG; i++)
            if (digits[i] != code_digit(i)) match = 0;
        digits.delete();
        full_at = p;
        if (match) begin
            push(EV_UON, p + 1, 0);
            fails = 0;
            unl_active = 1;
            unl_end = p + 1 + UNL;
        end else begin
            fails++;
            push(EV_ERR, p + 1, fails);
            push(EV_EOFF, p + 2, fails);
            if (fails == MAXF) begin
                push(EV_LON, p + 2, fails);
                push(EV_LOFF, p + 2 + LCK, 0);
                fails = 0;
                accept_from = p + 3 + LCK;
            end else begin
                accept_from = p + 3;
            end
        end
    endfunction

    function automatic void model_edge(int e, logic [3:0] r);
        bit pr = (r != 0);
        int d = -1;
        if (unl_active) begin
            if (pr || e == unl_end) begin
                push(EV_UOFF, e, 0);
                unl_active = 0;
                accept_from = e + 1;
            end
            return;
        end
        if (e < accept_from) return;
        if (pr) begin
            if ($countones(r) == 1)
                for (int i = 0; i < 4; i++) if (r[i]) d = i;
            digits.push_back(d);
            last_press = e;
            if (digits.size() == NDIG) finish_attempt(e);
        end
`ifdef LOCK_ENTRY_TIMEOUT_EN
        else if (digits.size() != 0 && e == last_press + TOUT) begin
            digits.delete();
        end
`endif
    endfunction

    function automatic void model_reset();
        digits.delete();
        fails = 0;
        accept_from = 0;
        unl_active = 0;
        full_at = -1;
        prev_btn = '1;
    endfunction

    // Called at a falling edge: drive btn for the next rising edge, advance
    // the model for that edge, then check the entry count after it.
    task automatic step(input logic [3:0] pat);
        logic [3:0] r;
        btn = pat;
        if (!rst_n) begin
            prev_btn = '1;
        end else begin
            r = pat & ~prev_btn;
            prev_btn = pat;
            model_edge(cyc + 1, r);
        end
        @(negedge clk);
        chk("digit_cnt", int'(digit_cnt), (cyc == full_at) ? NDIG : digits.size());
    endtask

    task automatic press(input logic [3:0] pat, input int gap);
        step(pat);
        step(4'b0000);
        repeat (gap) step(4'b0000);
    endtask

    task automatic enter(input int d0, input int d1, input int d2, input int d3);
        press(4'b0001 << d0, $urandom_range(0, 2));
        press(4'b0001 << d1, $urandom_range(0, 2));
        press(4'b0001 << d2, $urandom_range(0, 2));
        press(4'b0001 << d3, 0);
    endtask

    task automatic settle();
        for (int k = 0; k < 200 && (unl_active || cyc + 1 < accept_from); k++)
            step(4'b0000);
    endtask

    // Monitor: every output transition must match the head of the queue.
    bit pu = 0, pe = 0, pl = 0;

    function automatic void ev(ev_t k);
        exp_t x;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event %s at cycle %0d was not required", k.name(), cyc);
            return;
        end
        x = exp_q.pop_front();
        if (x.kind != k || x.at != cyc || x.fc != int'(fail_cnt)) begin
            errors++;
            $display("FAIL event actual=%s@%0d fail_cnt=%0d required=%s@%0d fail_cnt=%0d",
                     k.name(), cyc, fail_cnt, x.kind.name(), x.at, x.fc);
        end
    endfunction

    always @(negedge clk) begin
        if (pu && !unlocked)   ev(EV_UOFF);
        if (pe && !error)      ev(EV_EOFF);
        if (pl && !locked_out) ev(EV_LOFF);
        if (!pu && unlocked)   ev(EV_UON);
        if (!pe && error)      ev(EV_ERR);
        if (!pl && locked_out) ev(EV_LON);
        pu = unlocked;
        pe = error;
        pl = locked_out;
    end

    initial begin
        rst_n = 1'b0;
        btn   = 4'b0100;
        @(negedge clk);
        chk("reset unlocked", int'(unlocked), 0);
        chk("reset error", int'(error), 0);
        chk("reset locked_out", int'(locked_out), 0);
        chk("reset digit_cnt", int'(digit_cnt), 0);
        chk("reset fail_cnt", int'(fail_cnt), 0);

        // Button held across reset release must not register.
        repeat (2) step(4'b0100);
        rst_n = 1'b1;
        repeat (3) step(4'b0100);
        step(4'b0000);
        chk("held-through-reset digit_cnt", int'(digit_cnt), 0);

        enter(0, 1, 2, 3);
        settle();
        chk("after unlock fail_cnt", int'(fail_cnt), 0);

        enter(0, 1, 3, 3);
        settle();
        chk("one wrong fail_cnt", int'(fail_cnt), 1);
        chk("one wrong digit_cnt", int'(digit_cnt), 0);

        press(4'b0011, 1);
        press(4'b0010, 1);
        press(4'b0100, 1);
        press(4'b1000, 0);
        settle();
        chk("multi-press fail_cnt", int'(fail_cnt), 2);

        enter(3, 3, 3, 3);
        repeat (4) step(4'b0000);
        chk("lockout asserted", int'(locked_out), 1);
        for (int i = 0; i < 4; i++) press(4'b0001 << i, 1);
        chk("lockout digit_cnt", int'(digit_cnt), 0);
        settle();
        chk("after lockout fail_cnt", int'(fail_cnt), 0);

        // Partial entry left idle, then reset mid-entry.
        enter(2, 2, 2, 2);
        settle();
        press(4'b0001, 1);
        press(4'b0010, 0);
        repeat (TOUT + 5) step(4'b0000);
`ifdef LOCK_ENTRY_TIMEOUT_EN
        chk("idle partial digit_cnt", int'(digit_cnt), 0);
`else
        chk("idle partial digit_cnt", int'(digit_cnt), 2);
`endif
        chk("idle partial fail_cnt", int'(fail_cnt), 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid reset digit_cnt", int'(digit_cnt), 0);
        chk("mid reset fail_cnt", int'(fail_cnt), 0);
        chk("mid reset unlocked", int'(unlocked), 0);
        step(4'b0000);
        rst_n = 1'b1;
        step(4'b0000);

        for (int a = 0; a < 40; a++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if ($urandom_range(0, 1) == 1) settle();
            if (kind <= 4) begin
                enter(0, 1, 2, 3);
            end else if (kind <= 7) begin
                enter($urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3));
            end else if (kind == 8) begin
                int b0, b1;
                b0 = $urandom_range(0, 3);
                b1 = (b0 + $urandom_range(1, 3)) % 4;
                press((4'b0001 << b0) | (4'b0001 << b1), 1);
                press(4'b0010, 1);
                press(4'b0100, 1);
                press(4'b1000, 0);
            end else begin
                press(4'b0001 << $urandom_range(0, 3), 0);
            end
            repeat ($urandom_range(0, 25)) step(4'b0000);
        end

        for (int k = 0; k < 300 && (exp_q.size() != 0 || unl_active); k++)
            step(4'b0000);
        chk("outstanding events", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
